// File: rtl/branch_predictor_pkg.sv
// Shared counter encodings and update-kind type for the branch predictor.
package branch_predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t BP_SNT = 2'b00;
    localparam ctr_t BP_WNT = 2'b01;
    localparam ctr_t BP_WT  = 2'b10;
    localparam ctr_t BP_ST  = 2'b11;

    localparam ctr_t BP_CTR_RESET = BP_WNT;
    localparam ctr_t BP_CTR_ALLOC = BP_WT;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_TRAIN,
        UPD_ALLOC,
        UPD_INVAL
    } upd_e;

    function automatic logic ctr_predicts_taken(input ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function used on the BTB update path.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, EX-side training
// and mispredict/redirect generation. Optional statistics counters under BP_STATS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
`ifdef BP_STATS_EN
    output logic [31:0]     stat_ctl_cnt,
    output logic [31:0]     stat_mp_cnt,
`endif
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = XLEN - IDX_W - 2;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    logic             valid_q  [DEPTH];
    ctr_t             ctr_q    [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

    // IF lookup reads table state directly, so a same-cycle update is not visible yet.
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && ctr_predicts_taken(ctr_q[if_idx]);
        pred_target = pred_taken ? target_q[if_idx] : pc_inc(if_pc);
    end

    logic ctl;
    logic ex_hit;
    ctr_t ctr_trained;

    assign ctl    = ex_is_branch || ex_is_jump;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        mispredict = 1'b0;
        if (ex_valid) begin
            if (ctl && (ex_taken != ex_pred_taken))
                mispredict = 1'b1;
            else if (ctl && ex_taken && ex_pred_taken && (ex_target != ex_pred_target))
                mispredict = 1'b1;
            else if (!ctl && ex_pred_taken)
                mispredict = 1'b1;
        end
    end

    assign redirect_pc = (ctl && ex_taken) ? ex_target : pc_inc(ex_pc);

    bp_sat_counter u_sat_counter (
        .ctr      (ctr_q[ex_idx]),
        .taken    (ex_taken),
        .ctr_next (ctr_trained)
    );

    upd_e upd;
    ctr_t upd_ctr;
    logic upd_tgt;

    // Jump wins over branch when both flags are set.
    always_comb begin
        upd     = UPD_NONE;
        upd_ctr = ctr_q[ex_idx];
        upd_tgt = 1'b0;
        if (ex_valid) begin
            if (ex_is_jump) begin
                upd     = UPD_ALLOC;
                upd_ctr = BP_ST;
                upd_tgt = 1'b1;
            end else if (ex_is_branch) begin
                if (ex_hit) begin
                    upd     = UPD_TRAIN;
                    upd_ctr = ctr_trained;
                    upd_tgt = ex_taken;
                end else if (ex_taken) begin
                    upd     = UPD_ALLOC;
                    upd_ctr = BP_CTR_ALLOC;
                    upd_tgt = 1'b1;
                end
            end else if (ex_pred_taken) begin
                upd = UPD_INVAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= BP_CTR_RESET;
            end
        end else begin
            case (upd)
                UPD_ALLOC: begin
                    valid_q[ex_idx] <= 1'b1;
                    ctr_q[ex_idx]   <= upd_ctr;
                end
                UPD_TRAIN: ctr_q[ex_idx]   <= upd_ctr;
                UPD_INVAL: valid_q[ex_idx] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Tag/target are payload only; a stale value under valid=0 is never observed.
    always_ff @(posedge clk) begin
        if (upd == UPD_ALLOC) tag_q[ex_idx] <= ex_tag;
        if (upd_tgt) target_q[ex_idx] <= ex_target;
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_ctl_cnt <= '0;
            stat_mp_cnt  <= '0;
        end else begin
            if (ex_valid && ctl) stat_ctl_cnt <= stat_ctl_cnt + 32'd1;
            if (mispredict) stat_mp_cnt <= stat_mp_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset sequences, randomized model check.
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_ctl_cnt, stat_mp_cnt;
`endif

    branch_predictor #(.IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef BP_STATS_EN
        .stat_ctl_cnt   (stat_ctl_cnt),
        .stat_mp_cnt    (stat_mp_cnt),
`endif
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_ctl = 0;
    int exp_mp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] ifpc;
        logic        v, br, jp, tk;
        logic [31:0] expc, tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        hit, ptaken;
        logic [31:0] ptarget;
        logic        mp;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mkv(input logic [31:0] ifpc, input logic v, br, jp, tk,
                                 input logic [31:0] expc, tgt, input logic ptk,
                                 input logic [31:0] ptgt, input logic hit, ptaken,
                                 input logic [31:0] ptarget, input logic mp,
                                 input logic [31:0] rd);
        vec_t r;
        r.ifpc = ifpc; r.v = v; r.br = br; r.jp = jp; r.tk = tk;
        r.expc = expc; r.tgt = tgt; r.ptk = ptk; r.ptgt = ptgt;
        r.hit = hit; r.ptaken = ptaken; r.ptarget = ptarget; r.mp = mp; r.rd = rd;
        return r;
    endfunction

    vec_t vecs[$];

    // Reference model: plain per-entry arrays, counter kept as an integer 0..3.
    bit          m_valid [DEPTH];
    logic [25:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic hit, output logic tk,
                            output logic [31:0] tgt);
        int idx;
        idx = (pc / 4) % DEPTH;
        hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        tk  = hit && (m_ctr[idx] >= 2);
        tgt = tk ? m_tgt[idx] : pc + 32'd4;
    endtask

    task automatic m_update(input logic v, br, jp, tk, input logic [31:0] pc, tgt, input logic ptk);
        int idx;
        bit hit;
        idx = (pc / 4) % DEPTH;
        hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        if (!v) return;
        if (jp) begin
            m_valid[idx] = 1; m_tag[idx] = pc[31:6]; m_tgt[idx] = tgt; m_ctr[idx] = 3;
        end else if (br) begin
            if (hit) begin
                if (tk) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = tgt;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (tk) begin
                m_valid[idx] = 1; m_tag[idx] = pc[31:6]; m_tgt[idx] = tgt; m_ctr[idx] = 2;
            end
        end else if (ptk) begin
            m_valid[idx] = 0;
        end
    endtask

    function automatic logic [31:0] rpc();
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  lo;
        case ($urandom % 3)
            0:       tag = 26'h0;
            1:       tag = 26'h1;
            default: tag = 26'h3FFFFFF;
        endcase
        idx = 4'($urandom);
        lo  = 2'($urandom);
        return {tag, idx, lo};
    endfunction

    task automatic idle_ex();
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    initial begin
        rst = 1'b0;
        if_pc = 32'h100;
        idle_ex();

        vecs.push_back(mkv(32'h100, 0,0,0,0, 32'h000, 32'h000, 0, 32'h000, 0,0, 32'h104, 0, 32'h0));
        vecs.push_back(mkv(32'h100, 1,1,0,1, 32'h100, 32'h080, 0, 32'h104, 0,0, 32'h104, 1, 32'h080));
        vecs.push_back(mkv(32'h100, 1,1,0,0, 32'h100, 32'h000, 1, 32'h080, 1,1, 32'h080, 1, 32'h104));
        vecs.push_back(mkv(32'h100, 1,1,0,0, 32'h100, 32'h000, 0, 32'h104, 1,0, 32'h104, 0, 32'h0));
        vecs.push_back(mkv(32'h100, 1,1,0,0, 32'h100, 32'h000, 0, 32'h104, 1,0, 32'h104, 0, 32'h0));
        vecs.push_back(mkv(32'h100, 1,1,0,1, 32'h100, 32'h080, 0, 32'h104, 1,0, 32'h104, 1, 32'h080));
        vecs.push_back(mkv(32'h100, 1,1,0,1, 32'h100, 32'h080, 0, 32'h104, 1,0, 32'h104, 1, 32'h080));
        vecs.push_back(mkv(32'h100, 1,1,0,1, 32'h100, 32'h200, 1, 32'h080, 1,1, 32'h080, 1, 32'h200));
        vecs.push_back(mkv(32'h100, 1,0,0,0, 32'h140, 32'h000, 1, 32'h200, 1,1, 32'h200, 1, 32'h144));
        vecs.push_back(mkv(32'h100, 0,0,0,0, 32'h000, 32'h000, 0, 32'h000, 0,0, 32'h104, 0, 32'h0));
        vecs.push_back(mkv(32'h100, 1,1,1,1, 32'h100, 32'h300, 0, 32'h104, 0,0, 32'h104, 1, 32'h300));
        vecs.push_back(mkv(32'h100, 1,1,0,0, 32'h100, 32'h000, 1, 32'h300, 1,1, 32'h300, 1, 32'h104));
        vecs.push_back(mkv(32'h100, 0,0,0,0, 32'h100, 32'h000, 1, 32'h300, 1,1, 32'h300, 0, 32'h0));
        vecs.push_back(mkv(32'h140, 0,0,0,0, 32'h000, 32'h000, 0, 32'h000, 0,0, 32'h144, 0, 32'h0));
        vecs.push_back(mkv(32'h102, 0,0,0,0, 32'h000, 32'h000, 0, 32'h000, 1,1, 32'h300, 0, 32'h0));
        vecs.push_back(mkv(32'hFFFFFFFC, 1,1,0,0, 32'hFFFFFFFC, 32'h0, 1, 32'h100, 0,0, 32'h0, 1, 32'h0));
        vecs.push_back(mkv(32'h100, 1,1,0,1, 32'h100, 32'h300, 1, 32'h300, 1,1, 32'h300, 0, 32'h0));
        vecs.push_back(mkv(32'h104, 1,0,1,1, 32'h104, 32'h500, 1, 32'h500, 0,0, 32'h108, 0, 32'h0));
        vecs.push_back(mkv(32'h104, 0,0,0,0, 32'h000, 32'h000, 0, 32'h000, 1,1, 32'h500, 0, 32'h0));
        vecs.push_back(mkv(32'h100, 1,0,1,1, 32'h100, 32'h600, 1, 32'h300, 1,1, 32'h300, 1, 32'h600));
        vecs.push_back(mkv(32'h100, 0,0,0,0, 32'h000, 32'h000, 0, 32'h000, 1,1, 32'h600, 0, 32'h0));

        #3;
        chk("rst_hit", 32'(pred_hit), 32'd0);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_target", pred_target, 32'h104);
        chk("rst_mp", 32'(mispredict), 32'd0);
`ifdef BP_STATS_EN
        chk("rst_stat_ctl", stat_ctl_cnt, 32'd0);
        chk("rst_stat_mp", stat_mp_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (vecs[n]) begin
            if_pc = vecs[n].ifpc;
            ex_valid = vecs[n].v; ex_is_branch = vecs[n].br; ex_is_jump = vecs[n].jp;
            ex_taken = vecs[n].tk; ex_pc = vecs[n].expc; ex_target = vecs[n].tgt;
            ex_pred_taken = vecs[n].ptk; ex_pred_target = vecs[n].ptgt;
            #3;
            chk($sformatf("v%0d_hit", n), 32'(pred_hit), 32'(vecs[n].hit));
            chk($sformatf("v%0d_taken", n), 32'(pred_taken), 32'(vecs[n].ptaken));
            chk($sformatf("v%0d_target", n), pred_target, vecs[n].ptarget);
            chk($sformatf("v%0d_mp", n), 32'(mispredict), 32'(vecs[n].mp));
            if (vecs[n].mp) chk($sformatf("v%0d_redirect", n), redirect_pc, vecs[n].rd);
            if (vecs[n].v && (vecs[n].br || vecs[n].jp)) exp_ctl++;
            if (vecs[n].mp) exp_mp++;
            @(posedge clk); #1;
        end

`ifdef BP_STATS_EN
        chk("tbl_stat_ctl", stat_ctl_cnt, 32'(exp_ctl));
        chk("tbl_stat_mp", stat_mp_cnt, 32'(exp_mp));
`endif

        // Asynchronous reset in the middle of operation.
        idle_ex();
        if_pc = 32'h100;
        #2;
        chk("pre_rst_hit", 32'(pred_hit), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_hit", 32'(pred_hit), 32'd0);
        chk("async_rst_target", pred_target, 32'h104);
`ifdef BP_STATS_EN
        chk("async_rst_stat_ctl", stat_ctl_cnt, 32'd0);
        chk("async_rst_stat_mp", stat_mp_cnt, 32'd0);
`endif
        if_pc = 32'h104;
        #1;
        chk("async_rst_hit2", 32'(pred_hit), 32'd0);
        ex_valid = 1; ex_is_jump = 1; ex_taken = 1; ex_pc = 32'h108; ex_target = 32'h700;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_ex();
        if_pc = 32'h108;
        #1;
        chk("no_write_in_rst", 32'(pred_hit), 32'd0);
        exp_ctl = 0;
        exp_mp  = 0;
        m_reset();

        for (int c = 0; c < 400; c++) begin
            logic        h, t, ctl, mp_exp, eh, et;
            logic [31:0] g, eg, rd_exp;
            int          kind;
            if_pc = rpc();
            ex_valid = ($urandom % 4) != 0;
            kind = int'($urandom % 8);
            ex_is_branch = (kind < 4) || (kind == 6);
            ex_is_jump   = (kind == 4) || (kind == 5) || (kind == 6);
            ex_pc = rpc();
            ex_taken = ex_is_jump ? 1'b1 : 1'($urandom);
            ex_target = rpc() & 32'hFFFFFFFC;
            m_lookup(ex_pc, eh, et, eg);
            ex_pred_taken  = (($urandom % 8) == 0) ? ~et : et;
            ex_pred_target = (($urandom % 8) == 0) ? rpc() : eg;
            m_lookup(if_pc, h, t, g);
            ctl = ex_is_branch || ex_is_jump;
            mp_exp = ex_valid && ((ctl && (ex_taken != ex_pred_taken)) ||
                                  (ctl && ex_taken && ex_pred_taken && (ex_target != ex_pred_target)) ||
                                  (!ctl && ex_pred_taken));
            rd_exp = (ctl && ex_taken) ? ex_target : ex_pc + 32'd4;
            #3;
            chk("rnd_hit", 32'(pred_hit), 32'(h));
            chk("rnd_taken", 32'(pred_taken), 32'(t));
            chk("rnd_target", pred_target, g);
            chk("rnd_mp", 32'(mispredict), 32'(mp_exp));
            if (mp_exp) chk("rnd_redirect", redirect_pc, rd_exp);
            if (ex_valid && ctl) exp_ctl++;
            if (mp_exp) exp_mp++;
            m_update(ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pc, ex_target, ex_pred_taken);
            @(posedge clk); #1;
        end

`ifdef BP_STATS_EN
        chk("rnd_stat_ctl", stat_ctl_cnt, 32'(exp_ctl));
        chk("rnd_stat_mp", stat_mp_cnt, 32'(exp_mp));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
